// File: rtl/alu_exec.sv
// ============================================================================
// Module   : alu_exec
// Purpose  : Execution-stage ALU. Single-cycle logic/arithmetic ops and an
//            iterative 1-bit-per-cycle shifter, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             err
);

   localparam int SHAMT_W = $clog2(WIDTH);

   localparam logic [3:0] c_OP_AND = 4'b0000;
   localparam logic [3:0] c_OP_OR  = 4'b0001;
   localparam logic [3:0] c_OP_ADD = 4'b0010;
   localparam logic [3:0] c_OP_SLL = 4'b0011;
   localparam logic [3:0] c_OP_SRL = 4'b0100;
   localparam logic [3:0] c_OP_SRA = 4'b0101;
   localparam logic [3:0] c_OP_SUB = 4'b0110;

   localparam logic [1:0] c_S_IDLE  = 2'd0;
   localparam logic [1:0] c_S_SHIFT = 2'd1;
   localparam logic [1:0] c_S_DONE  = 2'd2;

   localparam logic [1:0] c_K_SLL = 2'd0;
   localparam logic [1:0] c_K_SRL = 2'd1;
   localparam logic [1:0] c_K_SRA = 2'd2;

   localparam logic [SHAMT_W-1:0] c_CNT_ONE = 1;

   logic [1:0]         r_state;
   logic [1:0]         w_state_next;
   logic [WIDTH-1:0]   r_result;
   logic               r_zero;
   logic               r_err;
   logic [WIDTH-1:0]   r_shreg;
   logic [SHAMT_W-1:0] r_cnt;
   logic [1:0]         r_kind;

   logic               w_accept;
   logic               w_is_shift;
   logic               w_legal;
   logic [1:0]         w_kind;
   logic [WIDTH-1:0]   w_alu;
   logic [WIDTH-1:0]   w_shift;

   assign w_accept = in_valid & in_ready;

   // Decode of the incoming op: single-cycle result, shift kind, legality.
   always_comb begin
      w_alu      = '0;
      w_is_shift = 1'b0;
      w_legal    = 1'b1;
      w_kind     = c_K_SLL;
      case (op)
         c_OP_AND: w_alu = a & b;
         c_OP_OR:  w_alu = a | b;
         c_OP_ADD: w_alu = a + b;
         c_OP_SUB: w_alu = a - b;
         c_OP_SLL: begin w_is_shift = 1'b1; w_kind = c_K_SLL; end
         c_OP_SRL: begin w_is_shift = 1'b1; w_kind = c_K_SRL; end
         c_OP_SRA: begin w_is_shift = 1'b1; w_kind = c_K_SRA; end
         default:  w_legal = 1'b0;
      endcase
   end

   always_comb begin
      w_shift = r_shreg;
      case (r_kind)
         c_K_SLL: w_shift = {r_shreg[WIDTH-2:0], 1'b0};
         c_K_SRL: w_shift = {1'b0, r_shreg[WIDTH-1:1]};
         c_K_SRA: w_shift = {r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]};
         default: w_shift = r_shreg;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_S_IDLE: begin
            if (w_accept) begin
               w_state_next = w_is_shift ? c_S_SHIFT : c_S_DONE;
            end
         end
         c_S_SHIFT: begin
            if (r_cnt == '0) begin
               w_state_next = c_S_DONE;
            end
         end
         c_S_DONE: begin
            if (out_ready) begin
               w_state_next = c_S_IDLE;
            end
         end
         default: w_state_next = c_S_IDLE;
      endcase
   end

   // Output logic; both handshake flags are forced low while reset is held
   always_comb begin
      in_ready  = (r_state == c_S_IDLE) & ~rst;
      out_valid = (r_state == c_S_DONE) & ~rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_result <= '0;
         r_zero   <= 1'b0;
         r_err    <= 1'b0;
         r_shreg  <= '0;
         r_cnt    <= '0;
         r_kind   <= c_K_SLL;
      end else begin
         case (r_state)
            c_S_IDLE: begin
               if (w_accept) begin
                  if (w_is_shift) begin
                     r_shreg <= a;
                     r_cnt   <= b[SHAMT_W-1:0];
                     r_kind  <= w_kind;
                  end else begin
                     r_result <= w_alu;
                     r_zero   <= (w_alu == '0);
                     r_err    <= ~w_legal;
                  end
               end
            end
            c_S_SHIFT: begin
               if (r_cnt != '0) begin
                  r_shreg <= w_shift;
                  r_cnt   <= r_cnt - c_CNT_ONE;
               end else begin
                  r_result <= r_shreg;
                  r_zero   <= (r_shreg == '0);
                  r_err    <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign result = r_result;
   assign zero   = r_zero;
   assign err    = r_err;

endmodule

`default_nettype wire
